night_sky: RTL and testbench



---
 rtl/night_sky.sv | 164 ++++++++++++++++
 tb/tb_night_sky.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/night_sky.sv
// night_sky: night-mode sky controller with scrolling moon/stars, fade FSM and per-star twinkle
module night_sky #(
    parameter int NUM_STARS      = 4,
    parameter int GAME_WIDTH     = 640,
    parameter int SPEED_SCALE    = 1024,
    parameter int MOON_SPEED     = 256,
    parameter int STAR_SPEED     = 307,
    parameter int MOON_WIDTH     = 20,
    parameter int STAR_MAX_Y     = 70,
    parameter int NUM_PHASES     = 7,
    parameter int VISIBLE_RATE   = 32,
    parameter int FADE_STEP      = 4,
    parameter int TWINKLE_PERIOD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               update,
    input  logic               crash,
    input  logic [3:0]         speed_mul,
    input  logic [5:0]         night_rate,
    input  logic [9:0]         star_x_rand  [NUM_STARS],
    input  logic [9:0]         star_y_rand  [NUM_STARS],
    output logic signed [10:0] moon_x_pos,
    output logic [9:0]         moon_width,
    output logic [2:0]         moon_phase,
    output logic signed [10:0] star_x_pos   [NUM_STARS],
    output logic [9:0]         star_y_pos   [NUM_STARS],
    output logic               star_twinkle [NUM_STARS],
    output logic [5:0]         alpha,
    output logic [1:0]         state,
    output logic               activated
);
    localparam logic [1:0] DAY = 2'd0, FADE_IN = 2'd1, NIGHT = 2'd2, FADE_OUT = 2'd3;
    localparam int SH = $clog2(SPEED_SCALE);
    localparam int TW = $clog2(TWINKLE_PERIOD);
    localparam int SEG = GAME_WIDTH / NUM_STARS;
    localparam logic signed [20:0] WRAP_POS = 21'(GAME_WIDTH * SPEED_SCALE);
    localparam logic signed [20:0] MIN_POS = 21'(-2 * MOON_WIDTH * SPEED_SCALE);

    logic [1:0]         state_q, state_d;
    logic [5:0]         alpha_q, alpha_d;
    logic [2:0]         phase_q, phase_d;
    logic signed [20:0] moon_pos_q, moon_pos_d;
    logic signed [20:0] star_pos_q [NUM_STARS];
    logic signed [20:0] star_pos_d [NUM_STARS];
    logic signed [20:0] star_next  [NUM_STARS];
    logic [9:0]         star_y_q   [NUM_STARS];
    logic [9:0]         star_y_d   [NUM_STARS];
    logic [TW-1:0]      tw_q       [NUM_STARS];
    logic [TW-1:0]      tw_d       [NUM_STARS];
    logic               req, move, activate;
    logic [6:0]         alpha_sum;
    logic [5:0]         alpha_up, alpha_dn;
    logic signed [20:0] moon_eff, star_eff, moon_next;

    function automatic logic signed [20:0] place_x(input int i, input logic [9:0] r);
        int c;
        c = (int'(r) > SEG - 1) ? SEG - 1 : int'(r);
        return 21'((SEG * i + c) * SPEED_SCALE);
    endfunction

    function automatic logic [9:0] clamp_y(input logic [9:0] r);
        return (r > 10'(STAR_MAX_Y)) ? 10'(STAR_MAX_Y) : r;
    endfunction

    assign req       = night_rate > 6'(VISIBLE_RATE);
    assign move      = update && state_q != DAY && !crash;
    assign alpha_sum = 7'(alpha_q) + 7'(FADE_STEP);
    assign alpha_up  = (alpha_sum > 7'd63) ? 6'd63 : alpha_sum[5:0];
    assign alpha_dn  = (alpha_q > 6'(FADE_STEP)) ? alpha_q - 6'(FADE_STEP) : 6'd0;
    assign moon_eff  = 21'((MOON_SPEED * 32'(speed_mul)) >> 2);
    assign star_eff  = 21'((STAR_SPEED * 32'(speed_mul)) >> 2);
    assign moon_next = moon_pos_q - moon_eff;

    always_comb begin
        state_d  = state_q;
        alpha_d  = alpha_q;
        phase_d  = phase_q;
        activate = 1'b0;
        if (update) begin
            case (state_q)
                DAY: if (req) begin
                    state_d  = FADE_IN;
                    activate = 1'b1;
                    phase_d  = (phase_q == 3'(NUM_PHASES - 1)) ? 3'd0 : phase_q + 3'd1;
                end
                FADE_IN: if (!req) begin
                    state_d = FADE_OUT;
                    alpha_d = alpha_dn;
                end else begin
                    alpha_d = alpha_up;
                    state_d = (alpha_up == 6'd63) ? NIGHT : FADE_IN;
                end
                NIGHT: state_d = req ? NIGHT : FADE_OUT;
                default: if (req) begin
                    state_d = FADE_IN;
                    alpha_d = alpha_up;
                end else begin
                    alpha_d = alpha_dn;
                    state_d = (alpha_dn == 6'd0) ? DAY : FADE_OUT;
                end
            endcase
        end
    end

    // Activation places stars without moving them; motion starts next update.
    always_comb begin
        moon_pos_d = move ? ((moon_next < MIN_POS) ? WRAP_POS : moon_next) : moon_pos_q;
        for (int i = 0; i < NUM_STARS; i++) begin
            star_next[i]  = star_pos_q[i] - star_eff;
            star_pos_d[i] = star_pos_q[i];
            star_y_d[i]   = star_y_q[i];
            tw_d[i]       = tw_q[i];
            if (activate) begin
                star_pos_d[i] = place_x(i, star_x_rand[i]);
                star_y_d[i]   = clamp_y(star_y_rand[i]);
                tw_d[i]       = TW'(i * TWINKLE_PERIOD / NUM_STARS);
            end else if (move) begin
                tw_d[i] = tw_q[i] + 1'b1;
                if (star_next[i] < MIN_POS) begin
                    star_pos_d[i] = WRAP_POS;
                    star_y_d[i]   = clamp_y(star_y_rand[i]);
                end else begin
                    star_pos_d[i] = star_next[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DAY;
            alpha_q    <= '0;
            phase_q    <= 3'(NUM_PHASES - 1);
            moon_pos_q <= 21'((GAME_WIDTH - 50) * SPEED_SCALE);
            for (int i = 0; i < NUM_STARS; i++) begin
                star_pos_q[i] <= '0;
                star_y_q[i]   <= '0;
                tw_q[i]       <= '0;
            end
        end else begin
            state_q    <= state_d;
            alpha_q    <= alpha_d;
            phase_q    <= phase_d;
            moon_pos_q <= moon_pos_d;
            star_pos_q <= star_pos_d;
            star_y_q   <= star_y_d;
            tw_q       <= tw_d;
        end
    end

    assign moon_x_pos = 11'(moon_pos_q >>> SH);
    assign moon_width = (phase_q == 3'd3) ? 10'(2 * MOON_WIDTH) : 10'(MOON_WIDTH);
    assign moon_phase = phase_q;
    assign alpha      = alpha_q;
    assign state      = state_q;
    assign activated  = state_q != DAY;

    for (genvar g = 0; g < NUM_STARS; g++) begin : g_out
        assign star_x_pos[g]   = 11'(star_pos_q[g] >>> SH);
        assign star_y_pos[g]   = star_y_q[g];
        assign star_twinkle[g] = tw_q[g][TW-1];
    end
endmodule

// File: tb/tb_night_sky.sv
// tb_night_sky: directed self-checking bench for night_sky with default parameters
module tb_night_sky;
    logic clk = 1'b0, rst = 1'b0, update = 1'b0, crash = 1'b0;
    logic [3:0] speed_mul = 4'd0;
    logic [5:0] night_rate = 6'd0;
    logic [9:0] x_rand [4];
    logic [9:0] y_rand [4];
    logic signed [10:0] moon_x_pos;
    logic signed [10:0] star_x_pos [4];
    logic [9:0] moon_width;
    logic [9:0] star_y_pos [4];
    logic [2:0] moon_phase;
    logic star_twinkle [4];
    logic [5:0] alpha;
    logic [1:0] state;
    logic activated;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    night_sky #(.NUM_STARS(4)) dut (
        .clk(clk), .rst(rst), .update(update), .crash(crash), .speed_mul(speed_mul),
        .night_rate(night_rate), .star_x_rand(x_rand), .star_y_rand(y_rand),
        .moon_x_pos(moon_x_pos), .moon_width(moon_width), .moon_phase(moon_phase),
        .star_x_pos(star_x_pos), .star_y_pos(star_y_pos), .star_twinkle(star_twinkle),
        .alpha(alpha), .state(state), .activated(activated)
    );

    task automatic step();
        @(negedge clk) update = 1'b1;
        @(negedge clk) update = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (moon_x_pos !== 11'sd590) $display("FAIL reset_moon_x got %0d exp 590", moon_x_pos); else passed++;
        total++; if (moon_phase !== 3'd6) $display("FAIL reset_phase got %0d exp 6", moon_phase); else passed++;
        total++; if (alpha !== 6'd0) $display("FAIL reset_alpha got %0d exp 0", alpha); else passed++;
        total++; if (state !== 2'd0 || activated !== 1'b0) $display("FAIL reset_state got %0d/%0d exp 0/0", state, activated); else passed++;
        total++; if (moon_width !== 10'd20) $display("FAIL reset_width got %0d exp 20", moon_width); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (star_x_pos[i] !== 11'sd0 || star_y_pos[i] !== 10'd0 || star_twinkle[i] !== 1'b0)
                $display("FAIL reset_star%0d got x=%0d y=%0d t=%0d exp 0/0/0", i, star_x_pos[i], star_y_pos[i], star_twinkle[i]);
            else passed++;
        end
        rst = 1'b1;
    endtask

    task automatic test_activation();
        int ex [4] = '{10, 319, 320, 485};
        int ey [4] = '{30, 70, 0, 70};
        logic et [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        x_rand = '{10'd10, 10'd200, 10'd0, 10'd5};
        y_rand = '{10'd30, 10'd100, 10'd0, 10'd70};
        night_rate = 6'd33;
        step();
        total++; if (state !== 2'd1 || activated !== 1'b1) $display("FAIL act_state got %0d/%0d exp 1/1", state, activated); else passed++;
        total++; if (moon_phase !== 3'd0) $display("FAIL act_phase got %0d exp 0", moon_phase); else passed++;
        total++; if (moon_x_pos !== 11'sd590) $display("FAIL act_moon_x got %0d exp 590", moon_x_pos); else passed++;
        total++; if (alpha !== 6'd0) $display("FAIL act_alpha got %0d exp 0", alpha); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (star_x_pos[i] !== 11'(ex[i]) || star_y_pos[i] !== 10'(ey[i]) || star_twinkle[i] !== et[i])
                $display("FAIL act_star%0d got x=%0d y=%0d t=%0d exp %0d/%0d/%0d", i, star_x_pos[i], star_y_pos[i], star_twinkle[i], ex[i], ey[i], et[i]);
            else passed++;
        end
    endtask

    task automatic test_fade();
        for (int k = 1; k <= 16; k++) begin
            step();
            total++; if (alpha !== 6'((k < 16) ? 4 * k : 63)) $display("FAIL fade_alpha%0d got %0d exp %0d", k, alpha, (k < 16) ? 4 * k : 63); else passed++;
            if (k == 7) begin total++; if (star_twinkle[0] !== 1'b0) $display("FAIL twinkle_k7 got %0d exp 0", star_twinkle[0]); else passed++; end
            if (k == 8) begin total++; if (star_twinkle[0] !== 1'b1) $display("FAIL twinkle_k8 got %0d exp 1", star_twinkle[0]); else passed++; end
        end
        total++; if (state !== 2'd2) $display("FAIL fade_night got %0d exp 2", state); else passed++;
        total++; if (star_x_pos[3] !== 11'sd485) $display("FAIL fade_star3_frozen got %0d exp 485", star_x_pos[3]); else passed++;
    endtask

    task automatic test_motion();
        int em [5] = '{589, 589, 589, 589, 588};
        speed_mul = 4'd4;
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (moon_x_pos !== 11'(em[k])) $display("FAIL motion_moon%0d got %0d exp %0d", k, moon_x_pos, em[k]); else passed++;
        end
        total++; if (star_x_pos[0] !== 11'sd8) $display("FAIL motion_star0 got %0d exp 8", star_x_pos[0]); else passed++;
        speed_mul = 4'd0;
        repeat (3) step();
        total++; if (moon_x_pos !== 11'sd588 || star_x_pos[0] !== 11'sd8) $display("FAIL speed0_pos got %0d/%0d exp 588/8", moon_x_pos, star_x_pos[0]); else passed++;
        total++; if (star_twinkle[0] !== 1'b1) $display("FAIL speed0_twinkle got %0d exp 1", star_twinkle[0]); else passed++;
        speed_mul = 4'd4;
        crash = 1'b1;
        repeat (8) step();
        crash = 1'b0;
        total++; if (moon_x_pos !== 11'sd588 || star_x_pos[0] !== 11'sd8) $display("FAIL crash_pos got %0d/%0d exp 588/8", moon_x_pos, star_x_pos[0]); else passed++;
        total++; if (star_twinkle[0] !== 1'b1 || star_twinkle[2] !== 1'b0) $display("FAIL crash_twinkle got %0d/%0d exp 1/0", star_twinkle[0], star_twinkle[2]); else passed++;
        total++; if (state !== 2'd2 || alpha !== 6'd63) $display("FAIL crash_fsm got %0d/%0d exp 2/63", state, alpha); else passed++;
    endtask

    task automatic test_wrap();
        speed_mul = 4'd15;
        y_rand = '{10'd500, 10'd500, 10'd500, 10'd500};
        repeat (43) step();
        total++; if (star_x_pos[0] !== -11'sd40 || star_y_pos[0] !== 10'd30) $display("FAIL prewrap_star0 got %0d/%0d exp -40/30", star_x_pos[0], star_y_pos[0]); else passed++;
        step();
        total++; if (star_x_pos[0] !== 11'sd640 || star_y_pos[0] !== 10'd70) $display("FAIL wrap_star0 got %0d/%0d exp 640/70", star_x_pos[0], star_y_pos[0]); else passed++;
        total++; if (star_y_pos[2] !== 10'd0) $display("FAIL nowrap_star2_y got %0d exp 0", star_y_pos[2]); else passed++;
        total++; if (moon_x_pos !== 11'sd547) $display("FAIL moon44 got %0d exp 547", moon_x_pos); else passed++;
        repeat (626) step();
        total++; if (moon_x_pos !== -11'sd40) $display("FAIL prewrap_moon got %0d exp -40", moon_x_pos); else passed++;
        step();
        total++; if (moon_x_pos !== 11'sd640) $display("FAIL wrap_moon got %0d exp 640", moon_x_pos); else passed++;
        step();
        total++; if (moon_x_pos !== 11'sd639) $display("FAIL postwrap_moon got %0d exp 639", moon_x_pos); else passed++;
    endtask

    task automatic test_fade_reverse();
        speed_mul = 4'd0;
        night_rate = 6'd32;
        step();
        total++; if (state !== 2'd3 || alpha !== 6'd63) $display("FAIL night_out got %0d/%0d exp 3/63", state, alpha); else passed++;
        repeat (15) step();
        total++; if (state !== 2'd3 || alpha !== 6'd3) $display("FAIL fadeout15 got %0d/%0d exp 3/3", state, alpha); else passed++;
        step();
        total++; if (state !== 2'd0 || alpha !== 6'd0 || activated !== 1'b0) $display("FAIL fadeout_day got %0d/%0d/%0d exp 0/0/0", state, alpha, activated); else passed++;
        night_rate = 6'd40;
        step();
        total++; if (state !== 2'd1 || moon_phase !== 3'd1) $display("FAIL react got %0d/%0d exp 1/1", state, moon_phase); else passed++;
        total++; if (star_x_pos[0] !== 11'sd10 || star_y_pos[0] !== 10'd70) $display("FAIL replace_star0 got %0d/%0d exp 10/70", star_x_pos[0], star_y_pos[0]); else passed++;
        total++; if (moon_x_pos !== 11'sd639) $display("FAIL react_moon got %0d exp 639", moon_x_pos); else passed++;
        repeat (10) step();
        total++; if (alpha !== 6'd40) $display("FAIL fadein40 got %0d exp 40", alpha); else passed++;
        night_rate = 6'd32;
        step();
        total++; if (state !== 2'd3 || alpha !== 6'd36) $display("FAIL reverse_out got %0d/%0d exp 3/36", state, alpha); else passed++;
        x_rand[1] = 10'd50;
        night_rate = 6'd33;
        step();
        total++; if (state !== 2'd1 || moon_phase !== 3'd1) $display("FAIL reverse_in got %0d/%0d exp 1/1", state, moon_phase); else passed++;
        total++; if (star_x_pos[1] !== 11'sd319) $display("FAIL reverse_noplace got %0d exp 319", star_x_pos[1]); else passed++;
    endtask

    task automatic test_reset_priority();
        @(negedge clk) begin rst = 1'b0; update = 1'b1; end
        @(negedge clk) begin rst = 1'b1; update = 1'b0; end
        total++; if (state !== 2'd0 || alpha !== 6'd0) $display("FAIL rstpri_fsm got %0d/%0d exp 0/0", state, alpha); else passed++;
        total++; if (moon_phase !== 3'd6 || moon_x_pos !== 11'sd590 || star_x_pos[1] !== 11'sd0) $display("FAIL rstpri_pos got %0d/%0d/%0d exp 6/590/0", moon_phase, moon_x_pos, star_x_pos[1]); else passed++;
    endtask

    task automatic test_moon_width();
        for (int c = 0; c < 4; c++) begin
            night_rate = 6'd33;
            step();
            total++; if (moon_phase !== 3'(c) || moon_width !== 10'((c == 3) ? 40 : 20)) $display("FAIL width_c%0d got %0d/%0d exp %0d/%0d", c, moon_phase, moon_width, c, (c == 3) ? 40 : 20); else passed++;
            night_rate = 6'd32;
            repeat (2) step();
        end
        total++; if (state !== 2'd0) $display("FAIL width_day got %0d exp 0", state); else passed++;
    endtask

    initial begin
        x_rand = '{10'd0, 10'd0, 10'd0, 10'd0};
        y_rand = '{10'd0, 10'd0, 10'd0, 10'd0};
        test_reset();
        test_activation();
        test_fade();
        test_motion();
        test_wrap();
        test_fade_reverse();
        test_reset_priority();
        test_moon_width();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
